// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and bridge FSM state encoding
package spi_pkg;
  localparam int FRAME_W       = 16;
  localparam int CMD_RW_BIT    = 15;
  localparam int CMD_BURST_BIT = 14;
  localparam logic [FRAME_W-1:0] IDLE_WORD_DEFAULT = 16'h5A00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_DATA   = 2'd3
  } state_e;
endpackage

// File: rtl/cs_sync.sv
// rtl/cs_sync.sv - two-flop chip-select synchroniser with rising-edge pulse
module cs_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs,
  output logic o_cs_rise
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to deasserted (high) so leaving reset never looks like a CS release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_cs;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_cs_rise = r_sync & ~r_prev;
endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - decodes SPI command/data frames into register strobes
// and feeds read data back to the SPI slave's MISO word.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int                 ADDR_W    = 6,
  parameter logic [FRAME_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cs,
  input  logic               rec_done,
  input  logic [FRAME_W-1:0] rec_data,
  output logic [FRAME_W-1:0] tx_data,
  output logic [ADDR_W-1:0]  reg_addr,
  output logic               reg_wr_en,
  output logic [FRAME_W-1:0] reg_wdata,
  output logic               reg_rd_en,
  input  logic [FRAME_W-1:0] reg_rdata,
  output logic               busy,
  output logic [7:0]         abort_cnt
);
  state_e             r_state;
  state_e             w_state_nxt;
  logic [FRAME_W-1:0] r_tx_data;
  logic [ADDR_W-1:0]  r_addr;
  logic [FRAME_W-1:0] r_wdata;
  logic               r_wr_en;
  logic               r_rw;
  logic               r_burst;
  logic               r_seen;
  logic [7:0]         r_abort_cnt;
  logic               w_cs_rise;
  logic               w_cmd_accept;
  logic               w_data_frame;
  logic               w_abort;

  cs_sync u_cs_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_cs      (i_cs),
    .o_cs_rise (w_cs_rise)
  );

  assign w_cmd_accept = (r_state == ST_IDLE) && rec_done && !w_cs_rise;
  assign w_data_frame = (r_state == ST_DATA) && rec_done;
  // A frame landing mid-fetch means the master outran us; CS release before any data frame abandons the command.
  assign w_abort = (rec_done && (r_state == ST_RD_REQ || r_state == ST_RD_CAP)) ||
                   (w_cs_rise && r_state != ST_IDLE && !r_seen && !w_data_frame);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_cmd_accept) w_state_nxt = rec_data[CMD_RW_BIT] ? ST_RD_REQ : ST_DATA;
      ST_RD_REQ: w_state_nxt = ST_RD_CAP;
      ST_RD_CAP: w_state_nxt = ST_DATA;
      ST_DATA:   if (rec_done) w_state_nxt = !r_burst ? ST_IDLE : (r_rw ? ST_RD_REQ : ST_DATA);
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    reg_rd_en = (r_state == ST_RD_REQ) && !w_cs_rise;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_data   <= IDLE_WORD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_rw        <= 1'b0;
      r_burst     <= 1'b0;
      r_seen      <= 1'b0;
      r_abort_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_cmd_accept) begin
        r_addr  <= rec_data[ADDR_W-1:0];
        r_rw    <= rec_data[CMD_RW_BIT];
        r_burst <= rec_data[CMD_BURST_BIT];
        r_seen  <= 1'b0;
      end
      if (w_data_frame) begin
        r_seen <= 1'b1;
        if (!r_rw) begin
          r_wdata <= rec_data;
          r_wr_en <= 1'b1;
        end else begin
          r_tx_data <= IDLE_WORD;
          if (r_burst) r_addr <= r_addr + 1'b1;
        end
      end
      // Write bursts advance only after the strobe so the strobe sees the current address.
      if (r_wr_en && r_burst && r_state == ST_DATA) r_addr <= r_addr + 1'b1;
      if (r_state == ST_RD_CAP && !w_cs_rise) r_tx_data <= reg_rdata;
      if (w_cs_rise) r_tx_data <= IDLE_WORD;
      if (w_abort && r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign tx_data   = r_tx_data;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr_en = r_wr_en;
  assign abort_cnt = r_abort_cnt;
endmodule
